fetch_unit: RTL and testbench

//   IF stage of the 5-stage MIPS pipeline: holds the fetch PC, drives the instruction-memory address,
//   and computes the next PC from the D-stage control decision and the D-stage comparator flag.
//   It also contains the F/D pipeline register that feeds decode.

---
 rtl/fetch_unit.sv | 102 ++++++++++
 tb/tb_fetch_unit.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: IF stage of the 5-stage MIPS pipeline.
// Holds the fetch PC, drives the instruction-memory address, selects the
// next PC from the D-stage control decision and owns the F/D register.
// Control transfers resolve in D with one delay slot. The delay slot is
// never annulled.
module fetch_unit #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000,
    parameter logic [31:0] IM_BASE  = 32'h0000_3000,
    parameter int          IM_WORDS = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [1:0]  npc_op,
    input  logic        flag,
    input  logic [15:0] d_imm16,
    input  logic [25:0] d_imm26,
    input  logic [31:0] d_rs,
    input  logic [31:0] im_instr,
    output logic [31:0] im_addr,
    output logic [31:0] D_instr,
    output logic [31:0] D_pc,
    output logic [31:0] D_pc8,
    output logic        D_adel
);

    localparam logic [1:0] NPC_SEQ    = 2'd0;
    localparam logic [1:0] NPC_BRANCH = 2'd1;
    localparam logic [1:0] NPC_JUMP   = 2'd2;
    localparam logic [1:0] NPC_JR     = 2'd3;

    // Highest legal word address in instruction memory.
    localparam logic [31:0] IM_LAST = IM_BASE + 32'(IM_WORDS * 4) - 32'd4;

    logic [31:0] f_pc;
    logic [31:0] next_pc;
    logic [31:0] seq_pc;
    logic [31:0] branch_off;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic        f_misaligned;
    logic        f_below;
    logic        f_above;
    logic        f_adel;

    assign im_addr = f_pc;

    // Candidate targets. The branch is relative to the delay-slot address
    // (D_pc+4); the jump keeps the region bits of the branch's own PC.
    always_comb begin
        seq_pc        = f_pc + 32'd4;
        branch_off    = {{14{d_imm16[15]}}, d_imm16, 2'b00};
        branch_target = D_pc + 32'd4 + branch_off;
        jump_target   = {D_pc[31:28], d_imm26, 2'b00};
    end

    // Next-PC select from the D-stage decision.
    always_comb begin
        next_pc = seq_pc;
        case (npc_op)
            NPC_SEQ:    next_pc = seq_pc;
            NPC_BRANCH: next_pc = flag ? branch_target : seq_pc;
            NPC_JUMP:   next_pc = jump_target;
            NPC_JR:     next_pc = d_rs;
            default:    next_pc = seq_pc;
        endcase
    end

    // Fetch address error: misaligned or outside the instruction memory.
    // A wrapped PC (0 after FFFF_FFFC) lands below IM_BASE and faults here.
    always_comb begin
        f_misaligned = (f_pc[1:0] != 2'b00);
        f_below      = (f_pc < IM_BASE);
        f_above      = (f_pc > IM_LAST);
        f_adel       = f_misaligned | f_below | f_above;
    end

    // Fetch PC register; stall freezes it, reset wins over stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            f_pc <= PC_RESET;
        end else if (!stall) begin
            f_pc <= next_pc;
        end
    end

    // F/D register; a faulting fetch is squashed to nop but keeps its PC.
    always_ff @(posedge clk) begin
        if (reset) begin
            D_instr <= 32'd0;
            D_pc    <= PC_RESET;
            D_pc8   <= PC_RESET + 32'd8;
            D_adel  <= 1'b0;
        end else if (!stall) begin
            D_instr <= f_adel ? 32'd0 : im_instr;
            D_pc    <= f_pc;
            D_pc8   <= f_pc + 32'd8;
            D_adel  <= f_adel;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed stimulus with a queue-based scoreboard.
// The driver pushes the hand-computed post-edge state; a monitor on the
// falling edge pops and compares against the DUT outputs.
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic        stall;
    logic [1:0]  npc_op;
    logic        flag;
    logic [15:0] d_imm16;
    logic [25:0] d_imm26;
    logic [31:0] d_rs;
    logic [31:0] im_instr;
    logic [31:0] im_addr;
    logic [31:0] D_instr;
    logic [31:0] D_pc;
    logic [31:0] D_pc8;
    logic        D_adel;

    typedef struct {
        logic [31:0] f;
        logic [31:0] dpc;
        logic [31:0] instr;
        logic        adel;
        string       tag;
    } exp_t;

    exp_t q[$];
    int   total;
    int   bad;

    fetch_unit dut (
        .clk      (clk),
        .reset    (reset),
        .stall    (stall),
        .npc_op   (npc_op),
        .flag     (flag),
        .d_imm16  (d_imm16),
        .d_imm26  (d_imm26),
        .d_rs     (d_rs),
        .im_instr (im_instr),
        .im_addr  (im_addr),
        .D_instr  (D_instr),
        .D_pc     (D_pc),
        .D_pc8    (D_pc8),
        .D_adel   (D_adel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction ROM contents: a fixed, address-dependent pattern.
    function automatic logic [31:0] rom(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    assign im_instr = rom(im_addr);

    task automatic cyc(input logic r, input logic s, input logic [1:0] op,
                       input logic fl, input logic [15:0] i16,
                       input logic [25:0] i26, input logic [31:0] rs,
                       input logic [31:0] ef, input logic [31:0] edpc,
                       input logic [31:0] einstr, input logic eadel,
                       input string tag);
        exp_t e;
        reset   = r;
        stall   = s;
        npc_op  = op;
        flag    = fl;
        d_imm16 = i16;
        d_imm26 = i26;
        d_rs    = rs;
        @(posedge clk);
        #1;
        e.f = ef; e.dpc = edpc; e.instr = einstr; e.adel = eadel; e.tag = tag;
        q.push_back(e);
    endtask

    task automatic seq(input logic [31:0] ef, input logic [31:0] edpc,
                       input logic [31:0] einstr, input logic eadel,
                       input string tag);
        cyc(1'b0, 1'b0, 2'd0, 1'b0, 16'h0, 26'h0, 32'h0, ef, edpc, einstr, eadel, tag);
    endtask

    // Monitor: compare the post-edge state on the falling edge.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            total = total + 4;
            if (im_addr !== e.f) begin
                bad = bad + 1;
                $display("FAIL %s im_addr got=%h want=%h", e.tag, im_addr, e.f);
            end
            if (D_pc !== e.dpc || D_pc8 !== e.dpc + 32'd8) begin
                bad = bad + 1;
                $display("FAIL %s D_pc/D_pc8 got=%h/%h want=%h/%h", e.tag, D_pc, D_pc8, e.dpc, e.dpc + 32'd8);
            end
            if (D_instr !== e.instr) begin
                bad = bad + 1;
                $display("FAIL %s D_instr got=%h want=%h", e.tag, D_instr, e.instr);
            end
            if (D_adel !== e.adel) begin
                bad = bad + 1;
                $display("FAIL %s D_adel got=%b want=%b", e.tag, D_adel, e.adel);
            end
        end
    end

    initial begin
        total = 0;
        bad   = 0;

        // 1: reset and free-running sequential fetch
        cyc(1, 0, 0, 0, 0, 0, 0, 32'h3000, 32'h3000, 32'h0, 0, "reset");
        seq(32'h3004, 32'h3000, rom(32'h3000), 0, "seq1");
        seq(32'h3008, 32'h3004, rom(32'h3004), 0, "seq2");
        seq(32'h300C, 32'h3008, rom(32'h3008), 0, "seq3");
        seq(32'h3010, 32'h300C, rom(32'h300C), 0, "seq4");

        // 2: branch with D_pc=3008, offset -8 bytes -> target 3004
        cyc(1, 0, 0, 0, 0, 0, 0, 32'h3000, 32'h3000, 32'h0, 0, "reset2");
        seq(32'h3004, 32'h3000, rom(32'h3000), 0, "b_pre1");
        seq(32'h3008, 32'h3004, rom(32'h3004), 0, "b_pre2");
        seq(32'h300C, 32'h3008, rom(32'h3008), 0, "b_pre3");
        cyc(0, 0, 1, 1, 16'hFFFE, 0, 0, 32'h3004, 32'h300C, rom(32'h300C), 0, "br_taken");
        seq(32'h3008, 32'h3004, rom(32'h3004), 0, "br_target_in_d");
        seq(32'h300C, 32'h3008, rom(32'h3008), 0, "b_pre4");
        cyc(0, 0, 1, 0, 16'hFFFE, 0, 0, 32'h3010, 32'h300C, rom(32'h300C), 0, "br_not_taken");
        seq(32'h3014, 32'h3010, rom(32'h3010), 0, "br_nt_next");

        // 3: j then back-to-back jr
        cyc(0, 0, 2, 0, 0, 26'h0000C40, 0, 32'h3100, 32'h3014, rom(32'h3014), 0, "jump");
        cyc(0, 0, 3, 0, 0, 0, 32'h3200, 32'h3200, 32'h3100, rom(32'h3100), 0, "jr_b2b");
        seq(32'h3204, 32'h3200, rom(32'h3200), 0, "jr_next");

        // 4: stall with a taken branch pending, then release
        cyc(0, 1, 1, 1, 16'h0010, 0, 0, 32'h3204, 32'h3200, rom(32'h3200), 0, "stall1");
        cyc(0, 1, 1, 1, 16'h0010, 0, 0, 32'h3204, 32'h3200, rom(32'h3200), 0, "stall2");
        cyc(0, 1, 1, 1, 16'h0010, 0, 0, 32'h3204, 32'h3200, rom(32'h3200), 0, "stall3");
        cyc(0, 0, 1, 1, 16'h0010, 0, 0, 32'h3244, 32'h3204, rom(32'h3204), 0, "stall_release_br");
        seq(32'h3248, 32'h3244, rom(32'h3244), 0, "stall_target_in_d");

        // 5: fetch address errors and boundaries
        cyc(0, 0, 3, 0, 0, 0, 32'h3002, 32'h3002, 32'h3248, rom(32'h3248), 0, "jr_misalign");
        cyc(0, 0, 3, 0, 0, 0, 32'h7000, 32'h7000, 32'h3002, 32'h0, 1, "adel_misalign");
        seq(32'h7004, 32'h7000, 32'h0, 1, "adel_above");
        cyc(0, 0, 3, 0, 0, 0, 32'h6FFC, 32'h6FFC, 32'h7004, 32'h0, 1, "adel_above2");
        seq(32'h7000, 32'h6FFC, rom(32'h6FFC), 0, "last_word_ok");
        cyc(0, 0, 3, 0, 0, 0, 32'h2FFC, 32'h2FFC, 32'h7000, 32'h0, 1, "jr_below");
        seq(32'h3000, 32'h2FFC, 32'h0, 1, "adel_below");
        cyc(0, 0, 3, 0, 0, 0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h3000, rom(32'h3000), 0, "jr_top");
        seq(32'h0000_0000, 32'hFFFF_FFFC, 32'h0, 1, "wrap");
        seq(32'h0000_0004, 32'h0000_0000, 32'h0, 1, "wrap_zero");

        // 6: reset beats stall and a pending jump
        cyc(1, 1, 2, 0, 0, 26'h0000C40, 0, 32'h3000, 32'h3000, 32'h0, 0, "reset_mid_stall");
        seq(32'h3004, 32'h3000, rom(32'h3000), 0, "post_reset");

        begin : drain
            int n;
            n = 0;
            while (q.size() > 0 && n < 20) begin
                @(posedge clk);
                n++;
            end
            if (q.size() > 0) begin
                bad = bad + 1;
                $display("FAIL drain pending=%0d want=0", q.size());
            end
        end
        @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
